// File: rtl/vic_video_pkg.sv
// Shared types for the VIC-II video path: colour index, 6-bit RGB triple,
// scan-doubler sequencer states and the C64 palette lookup.
package vic_video_pkg;

   typedef logic [3:0] color_idx_t;
   typedef logic [5:0] chan_t;

   typedef struct packed {
      chan_t r;
      chan_t g;
      chan_t b;
   } rgb_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS0 = 2'd1,
      ST_PASS1 = 2'd2
   } seq_state_t;

   // Classic C64 colours reduced to 6 bits per channel.
   function automatic rgb_t palette(input color_idx_t idx);
      rgb_t c;
      c = '0;
      case (idx)
         4'd0:  c = {6'h00, 6'h00, 6'h00};
         4'd1:  c = {6'h3F, 6'h3F, 6'h3F};
         4'd2:  c = {6'h1A, 6'h0D, 6'h0A};
         4'd3:  c = {6'h1C, 6'h29, 6'h2C};
         4'd4:  c = {6'h1B, 6'h0F, 6'h21};
         4'd5:  c = {6'h16, 6'h23, 6'h10};
         4'd6:  c = {6'h0D, 6'h0A, 6'h1E};
         4'd7:  c = {6'h2E, 6'h31, 6'h1B};
         4'd8:  c = {6'h1B, 6'h13, 6'h09};
         4'd9:  c = {6'h10, 6'h0E, 6'h00};
         4'd10: c = {6'h26, 6'h19, 6'h16};
         4'd11: c = {6'h11, 6'h11, 6'h11};
         4'd12: c = {6'h1B, 6'h1B, 6'h1B};
         4'd13: c = {6'h26, 6'h34, 6'h21};
         4'd14: c = {6'h1B, 6'h17, 6'h2D};
         default: c = {6'h25, 6'h25, 6'h25};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vic_scandoubler_if.sv
// VIC-II pixel stream in, VGA signals out; slave is the scan doubler side.
interface vic_scandoubler_if;
   import vic_video_pkg::*;

   logic       enaPixel;
   color_idx_t colorIndex;
   logic       hSync;
   logic       vSync;
   chan_t      vga_r;
   chan_t      vga_g;
   chan_t      vga_b;
   logic       vga_hs;
   logic       vga_vs;

   modport master (
      output enaPixel, colorIndex, hSync, vSync,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs
   );

   modport slave (
      input  enaPixel, colorIndex, hSync, vSync,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs
   );
endinterface

// File: rtl/vic_linebuf.sv
// Two-bank line buffer: simple dual-port RAM, bank select is the address MSB,
// registered read so it maps onto block RAM.
module vic_linebuf
   import vic_video_pkg::*;
#(
   parameter int ADDR_W = 10
)(
   input  logic            clk,
   input  logic            wr_en,
   input  logic [ADDR_W:0] wr_addr,
   input  color_idx_t      wr_data,
   input  logic [ADDR_W:0] rd_addr,
   output color_idx_t      rd_data
);

   color_idx_t mem [2**(ADDR_W+1)];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/vic_scandoubler.sv
// 15 kHz VIC-II stream to 31 kHz VGA: each input line is captured into one bank
// while the previous line is replayed twice at double pixel rate.
module vic_scandoubler
   import vic_video_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int HS_WIDTH = 64,
   parameter int MIN_LINE = 16,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
)(
   input logic              clk,
   input logic              reset,
   vic_scandoubler_if.slave vid
);

   localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
   localparam logic [ADDR_W:0]   MIN_LINE_W = (ADDR_W+1)'(MIN_LINE);
   localparam logic [ADDR_W:0]   HS_WIDTH_W = (ADDR_W+1)'(HS_WIDTH);
   localparam logic              HS_ACT     = (HS_POL != 0);
   localparam logic              VS_ACT     = (VS_POL != 0);

   logic              hs_reg, hs_dly_reg, start_reg;
   logic              wr_bank_reg, rd_bank_reg;
   logic [ADDR_W-1:0] wr_addr_reg, line_len_reg;
   logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
   seq_state_t        state_reg, state_next;
   logic              phase_reg, phase_next;
   logic              vs_pass_reg, vs_pass_next;
   logic              active1_reg, hs1_reg, vs1_reg;
   logic              hs2_reg, vs2_reg;
   rgb_t              rgb_reg;
   color_idx_t        rd_data;
   logic              accept, pass_end, active0, hs0, vs0;

   // Short lines are hSync glitches: no swap, the write counter keeps running.
   assign accept = start_reg && ({1'b0, wr_addr_reg} >= MIN_LINE_W);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_reg     <= 1'b0;
         hs_dly_reg <= 1'b0;
         start_reg  <= 1'b0;
      end else begin
         hs_reg     <= vid.hSync;
         hs_dly_reg <= hs_reg;
         start_reg  <= hs_reg & ~hs_dly_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank_reg  <= 1'b0;
         rd_bank_reg  <= 1'b0;
         wr_addr_reg  <= '0;
         line_len_reg <= '0;
      end else if (accept) begin
         wr_bank_reg  <= ~wr_bank_reg;
         rd_bank_reg  <= wr_bank_reg;
         line_len_reg <= wr_addr_reg;
         wr_addr_reg  <= '0;
      end else if (vid.enaPixel && (wr_addr_reg != ADDR_LAST)) begin
         wr_addr_reg  <= wr_addr_reg + ADDR_W'(1);
      end
   end

   vic_linebuf #(.ADDR_W(ADDR_W)) u_linebuf (
      .clk     (clk),
      .wr_en   (vid.enaPixel),
      .wr_addr ({wr_bank_reg, wr_addr_reg}),
      .wr_data (vid.colorIndex),
      .rd_addr ({rd_bank_reg, rd_addr_reg}),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         rd_addr_reg <= '0;
         phase_reg   <= 1'b0;
         vs_pass_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rd_addr_reg <= rd_addr_next;
         phase_reg   <= phase_next;
         vs_pass_reg <= vs_pass_next;
      end
   end

   // rd_addr advances on the second clk of each output pixel.
   always_comb begin
      state_next   = state_reg;
      rd_addr_next = rd_addr_reg;
      phase_next   = ~phase_reg;
      vs_pass_next = vs_pass_reg;
      pass_end     = (rd_addr_reg == line_len_reg - ADDR_W'(1));
      if (accept) begin
         state_next   = ST_PASS0;
         rd_addr_next = '0;
         phase_next   = 1'b0;
         vs_pass_next = vid.vSync;
      end else begin
         unique case (state_reg)
            ST_PASS0: begin
               if (phase_reg) begin
                  if (pass_end) begin
                     state_next   = ST_PASS1;
                     rd_addr_next = '0;
                     vs_pass_next = vid.vSync;
                  end else begin
                     rd_addr_next = rd_addr_reg + ADDR_W'(1);
                  end
               end
            end
            ST_PASS1: begin
               if (phase_reg) begin
                  if (pass_end) begin
                     state_next   = ST_IDLE;
                     rd_addr_next = '0;
                  end else begin
                     rd_addr_next = rd_addr_reg + ADDR_W'(1);
                  end
               end
            end
            default: phase_next = 1'b0;
         endcase
      end
   end

   assign active0 = (state_reg != ST_IDLE);
   assign hs0     = active0 && ({1'b0, rd_addr_reg} < HS_WIDTH_W);
   assign vs0     = active0 && vs_pass_reg;

   // Syncs ride one stage alongside the RAM read so they line up with RGB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active1_reg <= 1'b0;
         hs1_reg     <= 1'b0;
         vs1_reg     <= 1'b0;
         hs2_reg     <= 1'b0;
         vs2_reg     <= 1'b0;
         rgb_reg     <= '0;
      end else begin
         active1_reg <= active0;
         hs1_reg     <= hs0;
         vs1_reg     <= vs0;
         hs2_reg     <= hs1_reg;
         vs2_reg     <= vs1_reg;
         rgb_reg     <= (active1_reg && !hs1_reg && !vs1_reg) ? palette(rd_data) : '0;
      end
   end

   assign vid.vga_r  = rgb_reg.r;
   assign vid.vga_g  = rgb_reg.g;
   assign vid.vga_b  = rgb_reg.b;
   assign vid.vga_hs = hs2_reg ? HS_ACT : ~HS_ACT;
   assign vid.vga_vs = vs2_reg ? VS_ACT : ~VS_ACT;

endmodule

// File: tb/tb_vic_scandoubler.sv
// Directed input lines; each line queues its expected VGA samples by cycle and
// a separate monitor compares them as the cycles arrive.
module tb_vic_scandoubler;

   localparam int HSW    = 64;
   localparam int MINLEN = 16;
   localparam int MAXA   = 1023;

   typedef struct {
      int          cyc;
      int          line;
      int          pass;
      int          px;
      logic [17:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t       q[$];
   logic [3:0] cur_mem [1024];
   logic [3:0] shown   [1024];
   int         cnt        = 0;
   int         busy_until = 0;
   int         line_no    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vic_scandoubler_if vid();

   vic_scandoubler dut (
      .clk   (clk),
      .reset (reset),
      .vid   (vid)
   );

   function automatic logic [17:0] pal(input logic [3:0] i);
      case (i)
         4'd0:  return {6'h00, 6'h00, 6'h00};
         4'd1:  return {6'h3F, 6'h3F, 6'h3F};
         4'd2:  return {6'h1A, 6'h0D, 6'h0A};
         4'd3:  return {6'h1C, 6'h29, 6'h2C};
         4'd4:  return {6'h1B, 6'h0F, 6'h21};
         4'd5:  return {6'h16, 6'h23, 6'h10};
         4'd6:  return {6'h0D, 6'h0A, 6'h1E};
         4'd7:  return {6'h2E, 6'h31, 6'h1B};
         4'd8:  return {6'h1B, 6'h13, 6'h09};
         4'd9:  return {6'h10, 6'h0E, 6'h00};
         4'd10: return {6'h26, 6'h19, 6'h16};
         4'd11: return {6'h11, 6'h11, 6'h11};
         4'd12: return {6'h1B, 6'h1B, 6'h1B};
         4'd13: return {6'h26, 6'h34, 6'h21};
         4'd14: return {6'h1B, 6'h17, 6'h2D};
         default: return {6'h25, 6'h25, 6'h25};
      endcase
   endfunction

   // Active-low syncs at default polarity: active -> 0.
   function automatic void push(input int c, input int ln, input int ps, input int px,
                                input logic [17:0] rgb, input logic hs_act, input logic vs_act);
      exp_t e;
      e.cyc = c; e.line = ln; e.pass = ps; e.px = px;
      e.rgb = rgb; e.hs = ~hs_act; e.vs = ~vs_act;
      q.push_back(e);
   endfunction

   function automatic bit sel(input int p, input int len);
      return (p < 2) || (p >= 62 && p <= 80) || (p == len - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pat 0 = all white (index 1), pat 1 = ramp (pixel mod 16).
   task automatic send_line(input int npix, input int pat, input bit vs,
                            input int glitch_at, input int rst_at);
      int n, bound, len, c0, r;
      bit acc;
      logic [3:0] color;
      logic [17:0] rgb;
      n     = cyc;
      bound = (rst_at >= 0) ? n + 8 + 4 * rst_at - 1 : n + 8 + 4 * npix + 4;
      acc   = (cnt >= MINLEN);
      len   = acc ? cnt : 0;
      if (acc) begin
         for (int i = 0; i < len; i++) shown[i] = cur_mem[i];
         cnt = 0;
         for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < len; p++) begin
               if (sel(p, len)) begin
                  c0  = n + 5 + 2 * (k * len + p);
                  rgb = (p < HSW || vs) ? 18'h0 : pal(shown[p]);
                  for (int h = 0; h < 2; h++)
                     if (c0 + h <= bound) push(c0 + h, line_no, k, p, rgb, p < HSW, vs);
               end
            end
         end
         for (int h = 0; h < 2; h++)
            if (n + 5 + 4 * len + h <= bound) push(n + 5 + 4 * len + h, line_no, 2, 0, 18'h0, 1'b0, 1'b0);
         busy_until = n + 4 + 4 * len;
      end else begin
         for (int h = 5; h < 7; h++)
            if (n + h > busy_until && n + h <= bound) push(n + h, line_no, 2, 0, 18'h0, 1'b0, 1'b0);
      end
      $display("line %0d: %0d px pat %0d vs %0b accepted %0b replay_len %0d", line_no, npix, pat, vs, acc, len);

      vid.vSync = vs;
      vid.hSync = 1'b1;
      repeat (4) tick();
      vid.hSync = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < npix; i++) begin
         if (i == rst_at) begin
            reset = 1'b1;
            r = cyc;
            for (int h = 0; h < 3; h++) push(r + h, line_no, 3, 0, 18'h0, 1'b0, 1'b0);
            repeat (3) tick();
            reset = 1'b0;
            cnt = 0;
            busy_until = 0;
         end
         color = (pat == 0) ? 4'd1 : 4'(i);
         vid.enaPixel   = 1'b1;
         vid.colorIndex = color;
         cur_mem[cnt]   = color;
         if (cnt < MAXA) cnt++;
         tick();
         vid.enaPixel = 1'b0;
         if (i == glitch_at) vid.hSync = 1'b1;
         tick();
         vid.hSync = 1'b0;
         tick();
         tick();
      end
      line_no++;
   endtask

   // Monitor: pass 0/1 = replay passes, 2 = idle, 3 = under reset.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed line %0d pass %0d px %0d: expected at cycle %0d, now %0d",
                     e.line, e.pass, e.px, e.cyc, cyc);
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if ({vid.vga_r, vid.vga_g, vid.vga_b} !== e.rgb || vid.vga_hs !== e.hs || vid.vga_vs !== e.vs) begin
               errors++;
               $display("FAIL video line %0d pass %0d px %0d cycle %0d: got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                        e.line, e.pass, e.px, cyc, {vid.vga_r, vid.vga_g, vid.vga_b},
                        vid.vga_hs, vid.vga_vs, e.rgb, e.hs, e.vs);
            end
         end
      end
   end

   initial begin
      vid.enaPixel   = 1'b0;
      vid.colorIndex = 4'd0;
      vid.hSync      = 1'b0;
      vid.vSync      = 1'b0;
      for (int c = 1; c <= 3; c++) push(c, -1, 3, 0, 18'h0, 1'b0, 1'b0);
      repeat (3) tick();
      reset = 1'b0;

      send_line(520, 0, 1'b0, -1, -1);    // first edge after reset: nothing to replay
      send_line(520, 0, 1'b0, -1, -1);    // replays white
      send_line(520, 1, 1'b0, -1, -1);    // replays white, captures ramp
      send_line(520, 0, 1'b0,  7, -1);    // replays ramp, glitch after 8 pixels
      send_line(520, 1, 1'b0, -1, -1);    // replays 520-pixel white line
      send_line(520, 1, 1'b1, -1, -1);    // vSync lines: six blanked passes
      send_line(520, 1, 1'b1, -1, -1);
      send_line(520, 1, 1'b1, -1, -1);
      send_line(520, 1, 1'b0, -1, -1);
      send_line(1100, 1, 1'b0, -1, -1);   // overlong line saturates at 1023
      send_line(520, 1, 1'b0, -1, -1);    // replays 1023 pixels, PASS1 truncated
      send_line(520, 0, 1'b0, -1, 515);   // reset mid-line
      send_line(520, 0, 1'b0, -1, -1);    // too few pixels since reset: ignored
      send_line(520, 1, 1'b0, -1, -1);
      send_line(100, 0, 1'b0, -1, -1);    // short line truncates PASS0
      send_line(520, 1, 1'b0, -1, -1);    // replays 100-pixel line
      send_line(20, 0, 1'b0, -1, -1);

      for (int i = 0; i < 200 && q.size() > 0; i++) tick();
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected samples still queued, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vic_scandoubler.md
# vic_scandoubler

Converts the VIC-II 15 kHz pixel stream (4-bit colour index, hSync, vSync, pixel strobe) into a 31 kHz VGA stream driving VGA_R/G/B/HS/VS. It sits directly downstream of video_vicii_656x in the MAX top level. Each input line is written into one bank of a two-bank line buffer while the previous line is read out twice at double pixel rate through the 16-entry C64 palette.

## Interface
Parameters:
- ADDR_W, 10: line-buffer address width; depth 2^ADDR_W per bank.
- HS_WIDTH, 64: output hsync pulse width in output pixels.
- MIN_LINE, 16: input lines shorter than this many pixels are treated as hSync glitches.
- HS_POL, 0: output hsync polarity (0 = active-low).
- VS_POL, 0: output vsync polarity (0 = active-low).

Ports:
- clk  in  1  system clock (same clock as the VIC-II core); one clock.
- reset  in  1  asynchronous, active-high reset.
- enaPixel  in  1  input pixel strobe, one clk-wide pulse every 4 clk.
- colorIndex  in  4  VIC-II colour index, valid when enaPixel=1.
- hSync  in  1  VIC-II horizontal sync, active-high.
- vSync  in  1  VIC-II vertical sync, active-high.
- vga_r, vga_g, vga_b  out  6 each  palette colour.
- vga_hs  out  1  output hsync, polarity HS_POL.
- vga_vs  out  1  output vsync, polarity VS_POL.

## Operation
- Write side: wr_bank toggles on each accepted input line start; wr_addr resets to 0 there, then increments on each enaPixel, saturating at 2^ADDR_W-1 (surplus pixels overwrite the last entry).
- Line start = rising edge of registered hSync. Accepted only if wr_addr >= MIN_LINE; otherwise ignored (no bank swap, no length update, wr_addr keeps counting).
- On acceptance: line_len <= wr_addr (pixel count of the finished line); rd_bank <= previous wr_bank; output sequencer restarts.
- Output sequencer states: IDLE (after reset, until first accepted line), PASS0, PASS1. Accepted line start -> PASS0 from any state. PASS0 finishes after line_len output pixels -> PASS1. PASS1 finishes -> IDLE (output black, syncs inactive) until next line start.
- Output pixel = every 2nd clk (internal half-rate toggle cleared at line start). rd_addr runs 0..line_len-1 in each pass.
- vga_hs active for output pixels 0..HS_WIDTH-1 of each pass (clamped to line_len).
- vga_vs = input vSync sampled at each pass start, held for the whole pass.
- RGB = palette[colour] except forced 0 while vga_hs or vga_vs active, or in IDLE.
- Read and write always target different banks; no collision arbitration.

## Timing
- Reset: vga_r/g/b = 0, vga_hs and vga_vs inactive, state IDLE, wr_bank=0, wr_addr=0, line_len=0.
- hSync rising edge sampled into register at cycle T-1; edge detected at T; bank swap and rd_addr=0 at T+1; RAM data T+2; registered RGB and vga_hs asserted at T+3. Fixed 3-clk latency; hs/vs pipelined to stay aligned with RGB.
- Output pixel p of pass k (k=0,1) appears at T+3+2*(k*line_len+p), held 2 clk.
- New line start during PASS0/PASS1: current pass abandoned immediately, PASS0 of the new line begins with the same latency (truncation allowed).
- Reset asserted mid-line: all state cleared asynchronously; first output only after next accepted line start.
- line_len is ADDR_W bits; pass-end compare is rd_addr == line_len-1.

## Structure
- Package vic_video_pkg: C64 16-entry palette constant (6 bits/channel), colour-index typedef, sequencer state enum.
- One sub-module: vic_linebuf (simple dual-port, 2*2^ADDR_W x 4, registered read, independent write/read addresses).

## Test plan
- Reset mid-line: reset high for 3 clk -> RGB 0, syncs inactive; no output until second hSync edge.
- Steady 520-pixel lines of index 1 (white) -> two output lines per input line, each 1040 clk, RGB 63/63/63 outside hsync, 64-pixel hsync first in each.
- Ramp pattern index = pixel mod 16 -> output pixel p equals palette[p mod 16] in both passes, first pixel 3 clk after edge.
- hSync glitch after 8 pixels -> ignored; line_len stays 520, no bank swap.
- Overlong line of 1100 pixels -> line_len = 1023, last buffer entry holds pixel 1099 colour; next line start truncates PASS1.
- vSync high across 3 input lines -> vga_vs active for exactly 6 output passes, RGB forced 0 throughout.
